prog_divider: RTL and testbench

Parametrised clock-enable/divider generator, successor to the two-ratio FM divider. Produces a 50%-duty divided square wave plus single-cycle tick strobes from the system clock. Four selectable ratios: three fixed at elaboration, one runtime-programmable. Ratio changes are deferred to a full-period boundary so the output never glitches or emits a runt half-period. Feeds display scan, tone generation and slow-tick consumers.

---
 rtl/prog_divider.sv | 107 ++++++++++
 tb/tb_prog_divider.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_divider                                                 |
// | Description : 50%-duty clock divider with tick/rise strobes, three fixed   |
// |               ratios and one programmable ratio, switched glitch-free at   |
// |               full-period boundaries.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_divider #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] HALF0      = WIDTH'(6249999),
  parameter logic [WIDTH-1:0] HALF1      = WIDTH'(24999999),
  parameter logic [WIDTH-1:0] HALF2      = WIDTH'(0),
  parameter logic [WIDTH-1:0] PROG_RESET = WIDTH'(12499999)
) (
  input  logic             cin,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       fm,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic             cout,
  output logic             tick,
  output logic             rise,
  output logic             pending
);

  localparam logic [1:0] C_MODE_PROG = 2'd3;

  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] act_h_q, act_h_d;
  logic [1:0]       act_m_q, act_m_d;
  logic [WIDTH-1:0] prog_h_q, prog_h_d;
  logic             cout_q, cout_d;
  logic             tick_q, tick_d;
  logic             rise_q, rise_d;
  logic [WIDTH-1:0] req_h;

  // Requested terminal uses prog_h before any same-edge load.
  always_comb begin
    case (fm)
      2'd0:    req_h = HALF0;
      2'd1:    req_h = HALF1;
      2'd2:    req_h = HALF2;
      default: req_h = prog_h_q;
    endcase
  end

  always_comb begin
    c_d      = c_q;
    act_h_d  = act_h_q;
    act_m_d  = act_m_q;
    cout_d   = cout_q;
    tick_d   = 1'b0;
    rise_d   = 1'b0;
    prog_h_d = ld ? ld_val : prog_h_q;

    if (!en) begin
      // Idle: ratio requests are applied immediately.
      c_d     = '0;
      cout_d  = 1'b0;
      act_m_d = fm;
      act_h_d = req_h;
    end else if (c_q == act_h_q) begin
      c_d    = '0;
      cout_d = ~cout_q;
      tick_d = 1'b1;
      rise_d = ~cout_q;
      // High->low toggle closes a full period: safe point to switch ratio.
      if (cout_q) begin
        act_m_d = fm;
        act_h_d = req_h;
      end
    end else begin
      c_d = c_q + 1'b1;
    end
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      c_q      <= '0;
      act_h_q  <= HALF0;
      act_m_q  <= 2'd0;
      prog_h_q <= PROG_RESET;
      cout_q   <= 1'b0;
      tick_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      act_h_q  <= act_h_d;
      act_m_q  <= act_m_d;
      prog_h_q <= prog_h_d;
      cout_q   <= cout_d;
      tick_q   <= tick_d;
      rise_q   <= rise_d;
    end
  end

  assign cout    = cout_q;
  assign tick    = tick_q;
  assign rise    = rise_q;
  assign pending = en & ((fm != act_m_q) |
                         ((act_m_q == C_MODE_PROG) & (fm == C_MODE_PROG) &
                          (prog_h_q != act_h_q)));

endmodule
`default_nettype wire

// File: tb/tb_prog_divider.sv
`default_nettype none
// Self-checking bench for prog_divider: directed scenarios plus random traffic,
// compared against a half-length countdown model.
module tb_prog_divider;

  localparam int W = 8;
  localparam int H0 = 3, H1 = 1, H2 = 0, PR = 5;

  logic         cin = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   fm = 2'd0;
  logic         ld = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic         cout, tick, rise, pending;

  int checks = 0;
  int failures = 0;

  // Reference model: level, cycles left in current half, half length in cycles.
  logic m_lvl = 1'b0, m_tick = 1'b0, m_rise = 1'b0;
  int   m_mode = 0, m_hl = H0 + 1, m_rem = H0 + 1, m_prog = PR;

  prog_divider #(
    .WIDTH(W), .HALF0(8'd3), .HALF1(8'd1), .HALF2(8'd0), .PROG_RESET(8'd5)
  ) dut (
    .cin(cin), .rst(rst), .en(en), .fm(fm), .ld(ld), .ld_val(ld_val),
    .cout(cout), .tick(tick), .rise(rise), .pending(pending)
  );

  always #5 cin = ~cin;

  function automatic int half_len(input logic [1:0] f);
    case (f)
      2'd0:    return H0 + 1;
      2'd1:    return H1 + 1;
      2'd2:    return H2 + 1;
      default: return m_prog + 1;
    endcase
  endfunction

  function automatic logic pend_exp();
    return en && ((int'(fm) != m_mode) ||
                  (m_mode == 3 && fm == 2'd3 && (m_prog + 1) != m_hl));
  endfunction

  // Advance one clock: model steps on the rising edge, outputs settle by the falling edge.
  task automatic cycle();
    int req;
    @(posedge cin);
    req = half_len(fm);
    if (rst) begin
      m_lvl = 0; m_tick = 0; m_rise = 0; m_mode = 0;
      m_hl = H0 + 1; m_rem = m_hl; m_prog = PR;
    end else begin
      if (!en) begin
        m_lvl = 0; m_tick = 0; m_rise = 0;
        m_mode = int'(fm); m_hl = req; m_rem = m_hl;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_tick = 1; m_rise = !m_lvl;
          if (m_lvl) begin m_mode = int'(fm); m_hl = req; end
          m_lvl = !m_lvl;
          m_rem = m_hl;
        end else begin
          m_tick = 0; m_rise = 0;
        end
      end
      if (ld) m_prog = int'(ld_val);
    end
    @(negedge cin);
  endtask

  task automatic test_reset();
    rst = 1; en = 0; fm = 0; ld = 0;
    cycle(); cycle();
    checks++;
    if ({cout, tick, rise, pending} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {cout, tick, rise, pending});
    end
  endtask

  task automatic test_fm0_basic();
    rst = 0; en = 1; fm = 0;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      checks++;
      if (tick !== (e % 4 == 0) || rise !== (e % 8 == 4) || cout !== ((e % 8) >= 4)) begin
        failures++;
        $display("FAIL fm0_wave edge=%0d got c/t/r=%b%b%b", e, cout, tick, rise);
      end
      checks++;
      if ({cout, tick, rise, pending} !== {m_lvl, m_tick, m_rise, pend_exp()}) begin
        failures++;
        $display("FAIL fm0_model edge=%0d got=%b exp=%b", e, {cout, tick, rise, pending},
                 {m_lvl, m_tick, m_rise, pend_exp()});
      end
    end
  endtask

  task automatic test_fm2_div2();
    en = 0; fm = 2;
    cycle();
    en = 1;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      checks++;
      if (tick !== 1'b1 || rise !== (e % 2 == 1) || cout !== (e % 2 == 1)) begin
        failures++;
        $display("FAIL fm2_div2 edge=%0d got c/t/r=%b%b%b", e, cout, tick, rise);
      end
    end
  endtask

  task automatic test_switch_fm1();
    en = 0; fm = 0;
    cycle();
    en = 1;
    repeat (9) cycle();
    fm = 1;
    #1;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL switch_pending_set got=%b exp=1", pending);
    end
    for (int e = 10; e <= 24; e++) begin
      cycle();
      checks++;
      if (rise !== (e == 12 || e == 18 || e == 22) || pending !== (e < 16)) begin
        failures++;
        $display("FAIL switch_fm1 edge=%0d got rise=%b pend=%b", e, rise, pending);
      end
      checks++;
      if ({cout, tick, rise, pending} !== {m_lvl, m_tick, m_rise, pend_exp()}) begin
        failures++;
        $display("FAIL switch_model edge=%0d got=%b exp=%b", e, {cout, tick, rise, pending},
                 {m_lvl, m_tick, m_rise, pend_exp()});
      end
    end
  endtask

  task automatic test_prog_ld();
    int last_rise = -1, interval = 0;
    en = 0; fm = 3;
    cycle();
    en = 1;
    for (int e = 1; e <= 40; e++) begin
      ld = (e == 8); ld_val = 8'd2;
      cycle();
      if (e == 8) begin
        ld = 0;
        #1;
        checks++;
        if (pending !== 1'b1) begin
          failures++;
          $display("FAIL prog_pending got=%b exp=1", pending);
        end
      end
      if (e == 6) begin
        checks++;
        if (rise !== 1'b1) begin
          failures++;
          $display("FAIL prog_first_rise got=%b exp=1", rise);
        end
      end
      if (rise) begin
        if (last_rise >= 0) interval = e - last_rise;
        last_rise = e;
      end
      checks++;
      if ({cout, tick, rise, pending} !== {m_lvl, m_tick, m_rise, pend_exp()}) begin
        failures++;
        $display("FAIL prog_model edge=%0d got=%b exp=%b", e, {cout, tick, rise, pending},
                 {m_lvl, m_tick, m_rise, pend_exp()});
      end
    end
    checks++;
    if (interval != 6) begin
      failures++;
      $display("FAIL prog_period got=%0d exp=6", interval);
    end
  endtask

  task automatic test_disable();
    int n = 0;
    en = 0; fm = 0;
    cycle();
    en = 1;
    while (cout !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++;
    if (cout !== 1'b1) begin
      failures++;
      $display("FAIL disable_wait_high got=%b exp=1", cout);
    end
    cycle();
    en = 0;
    cycle();
    checks++;
    if (cout !== 1'b0 || tick !== 1'b0 || rise !== 1'b0) begin
      failures++;
      $display("FAIL disable_cout got c/t/r=%b%b%b exp=000", cout, tick, rise);
    end
    cycle();
    en = 1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      checks++;
      if (rise !== (e == 4)) begin
        failures++;
        $display("FAIL reenable_rise edge=%0d got=%b exp=%b", e, rise, (e == 4));
      end
    end
  endtask

  task automatic test_rst_mid();
    int last_rise = -1, interval = 0;
    en = 1; fm = 3; ld = 1; ld_val = 8'd9;
    cycle();
    ld = 0;
    repeat (10) cycle();
    rst = 1;
    cycle();
    checks++;
    if ({cout, tick, rise} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid got c/t/r=%b exp=000", {cout, tick, rise});
    end
    rst = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (rise) begin
        if (last_rise >= 0) interval = e - last_rise;
        last_rise = e;
      end
      checks++;
      if ({cout, tick, rise, pending} !== {m_lvl, m_tick, m_rise, pend_exp()}) begin
        failures++;
        $display("FAIL rst_mid_model edge=%0d got=%b exp=%b", e, {cout, tick, rise, pending},
                 {m_lvl, m_tick, m_rise, pend_exp()});
      end
    end
    checks++;
    if (interval != 12) begin
      failures++;
      $display("FAIL rst_mid_period got=%0d exp=12", interval);
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 600; e++) begin
      rst    = ($urandom_range(0, 99) < 2);
      en     = ($urandom_range(0, 99) < 92);
      fm     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : fm;
      ld     = ($urandom_range(0, 19) == 0);
      ld_val = 8'($urandom_range(0, 9));
      cycle();
      checks++;
      if ({cout, tick, rise, pending} !== {m_lvl, m_tick, m_rise, pend_exp()}) begin
        failures++;
        $display("FAIL random_model step=%0d got=%b exp=%b", e, {cout, tick, rise, pending},
                 {m_lvl, m_tick, m_rise, pend_exp()});
      end
    end
    rst = 0; ld = 0;
  endtask

  initial begin
    @(negedge cin);
    test_reset();
    test_fm0_basic();
    test_fm2_div2();
    test_switch_fm1();
    test_prog_ld();
    test_disable();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
